// File: rtl/reg_bus_pkg.sv
// Shared definitions for the tri-state register bus (reader and register side).
//   state_e    : reader FSM states
//   CS_IDLE    : all-ones select word (bus released); slice to NrOfRegs bits
//   nr_of_regs : number of registers addressable by an index of addr_bits
package reg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECT   = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  localparam int MAX_REGS = 64;
  localparam logic [MAX_REGS-1:0] CS_IDLE = '1;

  function automatic int nr_of_regs(input int addr_bits);
    return 1 << addr_bits;
  endfunction

endpackage

// File: rtl/reg_bus_cs_decoder.sv
// Registered one-cold chip-select decoder.
//   i_clk    : system clock
//   i_rst    : synchronous active-high reset, forces all selects high
//   i_index  : register to select in the next cycle
//   i_en     : 1 = drive cs[i_index] low next cycle, 0 = release the bus
//   o_cs     : active-low selects, at most one bit low
module reg_bus_cs_decoder
  import reg_bus_pkg::*;
#(
  parameter int AddrBits = 2,
  parameter int NrOfRegs = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [AddrBits-1:0] i_index,
  input  logic                i_en,
  output logic [NrOfRegs-1:0] o_cs
);

  logic [NrOfRegs-1:0] r_cs;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cs <= CS_IDLE[NrOfRegs-1:0];
    end else begin
      r_cs <= CS_IDLE[NrOfRegs-1:0];
      if (i_en) r_cs[i_index] <= 1'b0;
    end
  end

  assign o_cs = r_cs;

endmodule

// File: rtl/register_bus_reader.sv
// Read-side master for the shared tri-state register bus. Selects one register,
// holds its cs low for SettleCycles+1 Tick edges, captures the bus and offers the
// value over Valid/Ready. Supports single reads and bursts over all registers.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_tick       : FSM advance enable (handshake is not gated by it)
//   i_req/i_burst/i_addr : request, burst flag, single-read index
//   i_bus        : shared register bus
//   o_cs         : active-low per-register selects
//   o_data/o_index/o_last/o_valid, i_ready : captured word handshake
//   o_busy       : high whenever not idle
module register_bus_reader
  import reg_bus_pkg::*;
#(
  parameter int NrOfBits     = 8,
  parameter int AddrBits     = 2,
  parameter int SettleCycles = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_tick,
  input  logic                i_req,
  input  logic                i_burst,
  input  logic [AddrBits-1:0] i_addr,
  input  logic [NrOfBits-1:0] i_bus,
  output logic [(1<<AddrBits)-1:0] o_cs,
  output logic [NrOfBits-1:0] o_data,
  output logic [AddrBits-1:0] o_index,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_last,
  output logic                o_busy
);

  localparam int NrOfRegs = nr_of_regs(AddrBits);
  localparam logic [AddrBits-1:0] LAST_IDX = AddrBits'(NrOfRegs - 1);
  localparam logic [3:0] SETTLE = 4'(SettleCycles);

  state_e              r_state;
  logic [3:0]          r_cnt;
  logic [AddrBits-1:0] r_index;
  logic                r_burst;
  logic [NrOfBits-1:0] r_data;
  logic                r_valid;
  logic                r_last;
  logic                r_busy;

  logic                w_accept;
  logic                w_capture;
  logic                w_xfer;
  logic                w_advance;
  logic                w_sel_en;
  logic [AddrBits-1:0] w_sel_idx;

  assign w_accept  = (r_state == IDLE) && i_tick && i_req;
  assign w_capture = (r_state == SELECT) && i_tick && (r_cnt == 4'd0);
  assign w_xfer    = (r_state == WAIT_ACK) && r_valid && i_ready;
  assign w_advance = w_xfer && r_burst && !r_last;

  // cs is registered, so the decoder is fed with what the select should be
  // after this edge; that keeps cs aligned with the SELECT state.
  always_comb begin
    w_sel_en  = w_accept || w_advance || ((r_state == SELECT) && !w_capture);
    w_sel_idx = r_index;
    if (w_accept)       w_sel_idx = i_burst ? '0 : i_addr;
    else if (w_advance) w_sel_idx = r_index + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_index <= '0;
      r_burst <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_index <= w_sel_idx;
            r_burst <= i_burst;
            r_cnt   <= SETTLE;
            r_busy  <= 1'b1;
            r_state <= SELECT;
          end
        end
        SELECT: begin
          if (i_tick) begin
            if (r_cnt != 4'd0) begin
              r_cnt <= r_cnt - 4'd1;
            end else begin
              r_data  <= i_bus;
              r_valid <= 1'b1;
              r_last  <= !r_burst || (r_index == LAST_IDX);
              r_state <= WAIT_ACK;
            end
          end
        end
        WAIT_ACK: begin
          if (w_xfer) begin
            r_valid <= 1'b0;
            if (w_advance) begin
              r_index <= w_sel_idx;
              r_cnt   <= SETTLE;
              r_state <= SELECT;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  reg_bus_cs_decoder #(
    .AddrBits(AddrBits),
    .NrOfRegs(NrOfRegs)
  ) u_cs_dec (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_index(w_sel_idx),
    .i_en   (w_sel_en),
    .o_cs   (o_cs)
  );

  assign o_data  = r_data;
  assign o_index = r_index;
  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_register_bus_reader.sv
// Bench: two readers (SettleCycles 1 and 2) share stimulus; each gets its own
// bus model driven by the register array. A transaction-level model predicts the
// words each request yields and when selects/valid must appear.
module tb_register_bus_reader;

  localparam int NI = 2;
  localparam int NR = 4;
  localparam logic [3:0] CSF = 4'b1111;

  logic clk = 1'b0;
  logic rst, tick, req, burst, ready;
  logic [1:0] addr;
  logic [7:0] regs [NR];
  logic [7:0] noise;

  logic [3:0] cs    [NI];
  logic [7:0] data  [NI];
  logic [1:0] idx   [NI];
  logic       valid [NI];
  logic       last  [NI];
  logic       busy  [NI];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      logic [7:0] w_bus;
      // Released bus carries noise so a mistimed sample is visible.
      always_comb begin
        w_bus = noise;
        for (int i = 0; i < NR; i++) if (!cs[g][i]) w_bus = regs[i];
      end
      register_bus_reader #(.NrOfBits(8), .AddrBits(2), .SettleCycles(g + 1)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_req(req), .i_burst(burst),
        .i_addr(addr), .i_bus(w_bus), .o_cs(cs[g]), .o_data(data[g]), .o_index(idx[g]),
        .o_valid(valid[g]), .i_ready(ready), .o_last(last[g]), .o_busy(busy[g]));
    end
  endgenerate

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int   settle [NI] = '{1, 2};
  bit   m_busy [NI];
  int   q_idx  [NI][4];
  bit   q_last [NI][4];
  int   q_head [NI];
  int   q_cnt  [NI];
  int   sel_due[NI];
  int   low_ticks[NI];
  logic [3:0] prev_cs [NI];
  bit   prev_valid[NI];
  logic [7:0] log_d[$];
  bit         log_l[$];

  initial begin
    for (int k = 0; k < NI; k++) begin
      m_busy[k] = 0; q_head[k] = 0; q_cnt[k] = 0; sel_due[k] = -1;
      low_ticks[k] = 0; prev_cs[k] = CSF; prev_valid[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      string s;
      logic [3:0] exp_cs;
      bit acc, lst;
      s = $sformatf("u%0d", k);
      // ---- compare ----
      chk({s, "_one_cold"}, 32'($countones(~cs[k]) <= 1), 1);
      chk({s, "_busy"}, busy[k], m_busy[k]);
      if (!m_busy[k]) begin
        chk({s, "_idle_cs"}, cs[k], CSF);
        chk({s, "_idle_valid"}, valid[k], 0);
      end
      if (sel_due[k] >= 0) begin
        exp_cs = ~(4'b0001 << sel_due[k]);
        chk({s, "_select"}, cs[k], exp_cs);
      end
      if (prev_cs[k] != CSF && cs[k] != CSF)
        chk({s, "_break_before_make"}, cs[k], prev_cs[k]);
      if (prev_cs[k] != CSF && cs[k] == CSF) begin
        chk({s, "_settle_ticks"}, low_ticks[k], settle[k] + 1);
        chk({s, "_valid_after_capture"}, valid[k], 1);
      end
      if (cs[k] != CSF) chk({s, "_valid_while_sel"}, valid[k], 0);
      if (valid[k] && !prev_valid[k]) chk({s, "_valid_rise_src"}, prev_cs[k] != CSF, 1);
      if (valid[k]) begin
        chk({s, "_valid_expected"}, q_cnt[k] > 0, 1);
        if (q_cnt[k] > 0) begin
          chk({s, "_index"}, idx[k], q_idx[k][q_head[k]]);
          chk({s, "_last"}, last[k], q_last[k][q_head[k]]);
          chk({s, "_data"}, data[k], regs[q_idx[k][q_head[k]]]);
        end
      end
      // ---- advance model across the coming edge ----
      if (rst) begin
        m_busy[k] = 0; q_cnt[k] = 0; sel_due[k] = -1; low_ticks[k] = 0;
        prev_cs[k] = CSF; prev_valid[k] = 0;
      end else begin
        sel_due[k] = -1;
        if (cs[k] == CSF) low_ticks[k] = 0;
        else if (tick) low_ticks[k]++;
        prev_cs[k] = cs[k];
        prev_valid[k] = valid[k];
        acc = !m_busy[k] && tick && req;
        if (valid[k] && ready && q_cnt[k] > 0) begin
          lst = q_last[k][q_head[k]];
          if (k == 0) begin log_d.push_back(data[k]); log_l.push_back(last[k]); end
          q_head[k]++; q_cnt[k]--;
          if (lst) m_busy[k] = 0;
          else sel_due[k] = q_idx[k][q_head[k]];
        end
        if (acc) begin
          q_head[k] = 0;
          if (burst) begin
            q_cnt[k] = NR;
            for (int i = 0; i < NR; i++) begin q_idx[k][i] = i; q_last[k][i] = (i == NR - 1); end
          end else begin
            q_cnt[k] = 1; q_idx[k][0] = int'(addr); q_last[k][0] = 1;
          end
          m_busy[k] = 1;
          sel_due[k] = q_idx[k][0];
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((m_busy[0] || m_busy[1]) && n < maxc) begin step(); n++; end
    chk("idle_timeout", m_busy[0] | m_busy[1], 0);
  endtask

  initial begin
    int n;
    rst = 1; tick = 0; req = 1; burst = 0; addr = 0; ready = 0; noise = 8'hEE;
    regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'hA5; regs[3] = 8'h44;
    // 1. reset with Req held
    step(); step();
    for (int k = 0; k < NI; k++) begin
      chk("t1_cs", cs[k], 4'b1111);
      chk("t1_valid", valid[k], 0);
      chk("t1_busy", busy[k], 0);
      chk("t1_data", data[k], 8'h00);
      chk("t1_index", idx[k], 0);
      chk("t1_last", last[k], 0);
    end
    // 2. single read of reg 2 (instance 0, SettleCycles 1)
    rst = 0; tick = 1; ready = 1; req = 1; addr = 2; burst = 0;
    step(); req = 0;
    chk("t2_cs_c1", cs[0], 4'b1011);
    step();
    chk("t2_cs_c2", cs[0], 4'b1011);
    step();
    chk("t2_valid_c3", valid[0], 1);
    chk("t2_data_c3", data[0], 8'hA5);
    chk("t2_index_c3", idx[0], 2);
    chk("t2_last_c3", last[0], 1);
    chk("t2_cs_c3", cs[0], 4'b1111);
    step();
    chk("t2_busy_c4", busy[0], 0);
    wait_idle(50);
    // 3. burst
    regs[2] = 8'h33;
    log_d.delete(); log_l.delete();
    req = 1; burst = 1;
    step(); req = 0;
    wait_idle(100);
    chk("t3_count", log_d.size(), 4);
    if (log_d.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("t3_data", log_d[i], 8'((i + 1) * 17));
        chk("t3_last", log_l[i], i == 3);
      end
    // 4. backpressure on index 1
    req = 1; burst = 1;
    step(); req = 0;
    n = 0;
    while (!(valid[0] && idx[0] == 1) && n < 50) begin step(); n++; end
    chk("t4_reach", valid[0] && idx[0] == 1, 1);
    ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_cs", cs[0], 4'b1111);
      chk("t4_data", data[0], 8'h22);
      chk("t4_index", idx[0], 1);
      chk("t4_valid", valid[0], 1);
    end
    ready = 1;
    wait_idle(100);
    // 5. tick gating: req pulse with tick low, then one-in-three ticks
    tick = 0; req = 1; addr = 1; burst = 0;
    step(); req = 0;
    chk("t5_ignored0", busy[0], 0);
    chk("t5_ignored1", busy[1], 0);
    for (int c = 0; c < 60; c++) begin
      tick = (c % 3 == 0);
      req = (c == 3);
      step();
    end
    req = 0;
    for (int c = 0; c < 120 && (m_busy[0] || m_busy[1]); c++) begin
      tick = (c % 3 == 0);
      step();
    end
    tick = 1;
    wait_idle(50);
    // 6. reset mid-burst while selecting index 1
    req = 1; burst = 1; addr = 0;
    step(); req = 0;
    n = 0;
    while (cs[0] != 4'b1101 && n < 50) begin step(); n++; end
    chk("t6_reach", cs[0], 4'b1101);
    rst = 1;
    step(); rst = 0;
    chk("t6_cs", cs[0], 4'b1111);
    chk("t6_valid", valid[0], 0);
    chk("t6_busy", busy[0], 0);
    req = 1; burst = 0; addr = 3;
    step(); req = 0;
    chk("t6_restart_cs", cs[0], 4'b0111);
    wait_idle(50);
    // 7. randomized traffic
    for (int c = 0; c < 600; c++) begin
      if (!m_busy[0] && !m_busy[1] && $urandom_range(0, 3) == 0)
        for (int i = 0; i < NR; i++) regs[i] = 8'($urandom);
      noise = 8'($urandom);
      tick  = $urandom_range(0, 3) != 0;
      req   = $urandom_range(0, 3) == 0;
      burst = $urandom_range(0, 2) == 0;
      addr  = 2'($urandom);
      ready = $urandom_range(0, 2) != 0;
      rst   = $urandom_range(0, 149) == 0;
      step();
    end
    rst = 0; req = 0; tick = 1; ready = 1;
    wait_idle(100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
